// File: rtl/carry_output_scheduler.sv
// carry_output_scheduler
// Merges the main and auxiliary carry-stage byte outputs into one byte stream
// through a circular FIFO. Each cycle one source is selected by sel_aux and
// pushes 0-3 bytes. The FIFO drains one byte per cycle over valid/ready, and
// a per-frame start/flush/done sequence wraps the whole thing.
// Optional build macro: CARRY_SCHED_STATS_EN adds the aux_push_count output.
//
// state | meaning
// IDLE  | waiting for in_start
// RUN   | accepting pushes, draining
// FLUSH | no more pushes, draining until empty
// DONE  | one-cycle done pulse, then back to IDLE
module carry_output_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int STALL_MARGIN = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_start,
    input  logic                  in_end,
    input  logic [1:0]            main_flag,
    input  logic [DATA_WIDTH-1:0] main_bit_1,
    input  logic [DATA_WIDTH-1:0] main_bit_2,
    input  logic [2:0]            aux_flag,
    input  logic [DATA_WIDTH-1:0] aux_bit_1,
    input  logic [DATA_WIDTH-1:0] aux_bit_2,
    input  logic [DATA_WIDTH-1:0] aux_bit_3,
    input  logic                  sel_aux,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_byte,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  error_overflow,
`ifdef CARRY_SCHED_STATS_EN
    output logic [15:0]           aux_push_count,
`endif
    output logic [15:0]           byte_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] MARGIN_V = (ADDR_WIDTH + 1)'(STALL_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   occupancy;
    logic [ADDR_WIDTH:0]   free_slots;
    logic [1:0]            n_req;
    logic [1:0]            n_acc;
    logic [DATA_WIDTH-1:0] src_byte [3];
    logic                  push_req;
    logic                  overflow_hit;
    logic                  pop;
    logic                  start_accept;

    // Source selection and push-count decode; unlisted flag codes mean "no bytes".
    always_comb begin
        n_req       = 2'd0;
        src_byte[0] = main_bit_1;
        src_byte[1] = main_bit_2;
        src_byte[2] = aux_bit_3;
        if (sel_aux) begin
            src_byte[0] = aux_bit_1;
            src_byte[1] = aux_bit_2;
            case (aux_flag)
                3'b001:  n_req = 2'd1;
                3'b011:  n_req = 2'd2;
                3'b010:  n_req = 2'd3;
                default: n_req = 2'd0;
            endcase
        end else begin
            case (main_flag)
                2'b01:   n_req = 2'd1;
                2'b11:   n_req = 2'd2;
                default: n_req = 2'd0;
            endcase
        end
    end

    // Push acceptance: all-or-nothing against free space measured before this cycle's pop.
    always_comb begin
        free_slots   = DEPTH_V - occupancy;
        push_req     = (state == S_RUN) && (n_req != 2'd0);
        overflow_hit = push_req && ((ADDR_WIDTH + 1)'(n_req) > free_slots);
        n_acc        = (push_req && !overflow_hit) ? n_req : 2'd0;
        start_accept = (state == S_IDLE) && in_start;
        out_valid    = (occupancy != '0) && ((state == S_RUN) || (state == S_FLUSH));
        out_byte     = out_valid ? mem[rd_ptr] : '0;
        out_last     = out_valid && (state == S_FLUSH) && (occupancy == (ADDR_WIDTH + 1)'(1));
        pop          = out_valid && out_ready;
        stall        = free_slots < MARGIN_V;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
    end

    // Frame sequencing next-state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_start) state_next = S_RUN;
            S_RUN:   if (in_end) state_next = S_FLUSH;
            S_FLUSH: if (occupancy == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // FIFO storage: accepted bytes land at consecutive slots from wr_ptr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i < int'(n_acc)) mem[wr_ptr + ADDR_WIDTH'(i)] <= src_byte[i];
            end
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the FIFO depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + ADDR_WIDTH'(n_acc);
            rd_ptr    <= rd_ptr + ADDR_WIDTH'(pop);
            occupancy <= occupancy + (ADDR_WIDTH + 1)'(n_acc) - (ADDR_WIDTH + 1)'(pop);
        end
    end

    // Per-frame popped-byte count and sticky overflow flag, both cleared by an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_count     <= '0;
            error_overflow <= 1'b0;
        end else begin
            if (start_accept)                     byte_count <= '0;
            else if (pop && byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
            if (start_accept)      error_overflow <= 1'b0;
            else if (overflow_hit) error_overflow <= 1'b1;
        end
    end

`ifdef CARRY_SCHED_STATS_EN
    // Counts cycles where an auxiliary push was accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aux_push_count <= '0;
        end else if (start_accept) begin
            aux_push_count <= '0;
        end else if (sel_aux && (n_acc != 2'd0) && aux_push_count != 16'hFFFF) begin
            aux_push_count <= aux_push_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_carry_output_scheduler.sv
// Testbench for carry_output_scheduler: directed frames plus randomized frames,
// every cycle compared against a queue-based reference model.
module tb_carry_output_scheduler;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_start = 1'b0;
    logic       in_end = 1'b0;
    logic [1:0] main_flag = '0;
    logic [7:0] main_bit_1 = '0, main_bit_2 = '0;
    logic [2:0] aux_flag = '0;
    logic [7:0] aux_bit_1 = '0, aux_bit_2 = '0, aux_bit_3 = '0;
    logic       sel_aux = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_last, stall, busy, done, error_overflow;
    logic [7:0] out_byte;
    logic [15:0] byte_count;
`ifdef CARRY_SCHED_STATS_EN
    logic [15:0] aux_push_count;
`endif

    carry_output_scheduler dut (
        .clk(clk), .reset(reset), .in_start(in_start), .in_end(in_end),
        .main_flag(main_flag), .main_bit_1(main_bit_1), .main_bit_2(main_bit_2),
        .aux_flag(aux_flag), .aux_bit_1(aux_bit_1), .aux_bit_2(aux_bit_2), .aux_bit_3(aux_bit_3),
        .sel_aux(sel_aux), .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
        .out_last(out_last), .stall(stall), .busy(busy), .done(done),
        .error_overflow(error_overflow),
`ifdef CARRY_SCHED_STATS_EN
        .aux_push_count(aux_push_count),
`endif
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: frame phase 0 idle, 1 run, 2 flush, 3 done.
    int         m_phase = 0;
    logic [7:0] mq[$];
    bit         m_ovf = 0;
    int         m_cnt = 0;
    int         m_aux = 0;
    logic [7:0] out_log[$];
    int         done_seen = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int bytes_offered();
        if (sel_aux) begin
            case (aux_flag)
                3'b001: return 1;
                3'b011: return 2;
                3'b010: return 3;
                default: return 0;
            endcase
        end
        case (main_flag)
            2'b01: return 1;
            2'b11: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic clear_inputs();
        in_start = 0; in_end = 0; sel_aux = 0;
        main_flag = 0; aux_flag = 0;
        main_bit_1 = 0; main_bit_2 = 0;
        aux_bit_1 = 0; aux_bit_2 = 0; aux_bit_3 = 0;
    endtask

    // Compare outputs against the model, advance the model, then clock once.
    task automatic cycle();
        int n, size0;
        bit exp_valid, pop;
        logic [7:0] b[3];
        #1;
        size0 = mq.size();
        exp_valid = (size0 != 0) && (m_phase == 1 || m_phase == 2);
        check_value("out_valid", out_valid, exp_valid);
        if (exp_valid && out_valid) check_value("out_byte", out_byte, mq[0]);
        check_value("out_last", out_last, exp_valid && m_phase == 2 && size0 == 1);
        check_value("stall", stall, (DEPTH - size0) < 3);
        check_value("busy", busy, m_phase != 0);
        check_value("done", done, m_phase == 3);
        check_value("error_overflow", error_overflow, m_ovf);
        check_value("byte_count", byte_count, m_cnt);
`ifdef CARRY_SCHED_STATS_EN
        check_value("aux_push_count", aux_push_count, m_aux);
`endif
        if (done) done_seen++;
        if (out_valid && out_ready) out_log.push_back(out_byte);
        pop = exp_valid && out_ready;
        n = bytes_offered();
        if (sel_aux) begin b[0] = aux_bit_1; b[1] = aux_bit_2; b[2] = aux_bit_3; end
        else begin b[0] = main_bit_1; b[1] = main_bit_2; b[2] = 8'h00; end
        case (m_phase)
            0: if (in_start) begin m_phase = 1; m_ovf = 0; m_cnt = 0; m_aux = 0; end
            1: begin
                if (n > 0) begin
                    if (n > DEPTH - size0) m_ovf = 1;
                    else begin
                        for (int i = 0; i < n; i++) mq.push_back(b[i]);
                        if (sel_aux && m_aux < 65535) m_aux++;
                    end
                end
                if (in_end) m_phase = 2;
            end
            2: if (size0 == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
        if (pop) begin
            void'(mq.pop_front());
            if (m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1;
        #1;
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_out_byte", out_byte, 0);
        check_value("rst_out_last", out_last, 0);
        check_value("rst_stall", stall, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_overflow", error_overflow, 0);
        check_value("rst_byte_count", byte_count, 0);
        mq.delete(); m_phase = 0; m_ovf = 0; m_cnt = 0; m_aux = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2 reset = 0;
        @(posedge clk);
        #1;
    endtask

    // Drain mode: 0 ready always, 1 ready toggles, 2 ready random.
    task automatic drain(input int mode);
        int guard = 0;
        clear_inputs();
        while (m_phase != 0 && guard < 200) begin
            case (mode)
                0: out_ready = 1;
                1: out_ready = ~out_ready;
                default: out_ready = ($urandom % 4) != 0;
            endcase
            cycle();
            guard++;
        end
        if (m_phase != 0) check_value("drain_timeout", guard, 0);
    endtask

    task automatic start_frame();
        clear_inputs();
        out_log.delete();
        done_seen = 0;
        in_start = 1;
        cycle();
        in_start = 0;
    endtask

    initial begin
        logic [7:0] exp_t2[3];
        int v;

        apply_reset();

        // Basic frame from the main source.
        start_frame();
        out_ready = 1;
        main_flag = 2'b01; main_bit_1 = 8'h12;
        cycle();
        main_flag = 2'b11; main_bit_1 = 8'h34; main_bit_2 = 8'h56; in_end = 1;
        cycle();
        drain(0);
        check_value("t1_len", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check_value("t1_b0", out_log[0], 8'h12);
            check_value("t1_b1", out_log[1], 8'h34);
            check_value("t1_b2", out_log[2], 8'h56);
        end
        check_value("t1_count", byte_count, 3);
        check_value("t1_done_pulses", done_seen, 1);

        // Auxiliary selected; main bytes in the same cycle must be dropped.
        start_frame();
        out_ready = 1;
        sel_aux = 1; aux_flag = 3'b010;
        aux_bit_1 = 8'hFF; aux_bit_2 = 8'hFF; aux_bit_3 = 8'h00;
        main_flag = 2'b11; main_bit_1 = 8'hAA; main_bit_2 = 8'hBB; in_end = 1;
        cycle();
        drain(0);
        exp_t2[0] = 8'hFF; exp_t2[1] = 8'hFF; exp_t2[2] = 8'h00;
        check_value("t2_len", out_log.size(), 3);
        if (out_log.size() == 3)
            for (int i = 0; i < 3; i++) check_value("t2_byte", out_log[i], exp_t2[i]);

        // Back-pressure and overflow: three bytes per cycle with out_ready low.
        start_frame();
        out_ready = 0;
        for (int k = 0; k < 6; k++) begin
            sel_aux = 1; aux_flag = 3'b010;
            aux_bit_1 = 8'(3 * k); aux_bit_2 = 8'(3 * k + 1); aux_bit_3 = 8'(3 * k + 2);
            cycle();
            if (k == 3) check_value("t3_stall_occ12", stall, 0);
            if (k == 4) check_value("t3_stall_occ15", stall, 1);
        end
        check_value("t3_overflow_set", error_overflow, 1);
        clear_inputs();
        in_end = 1;
        cycle();
        drain(0);
        check_value("t3_len", out_log.size(), 15);
        check_value("t3_overflow_held", error_overflow, 1);

        // Empty frame; also confirms the overflow flag clears on start.
        start_frame();
        check_value("t5_overflow_cleared", error_overflow, 0);
        in_end = 1;
        cycle();
        drain(0);
        check_value("t5_count", byte_count, 0);
        check_value("t5_log", out_log.size(), 0);
        check_value("t5_done_pulses", done_seen, 1);

        // Wrap-around: 20 sequential bytes with out_ready toggling.
        start_frame();
        v = 0;
        out_ready = 0;
        while (v < 20) begin
            clear_inputs();
            out_ready = ~out_ready;
            if (v < 19 && ($urandom % 2) == 1) begin
                main_flag = 2'b11; main_bit_1 = 8'(v); main_bit_2 = 8'(v + 1); v += 2;
            end else begin
                main_flag = 2'b01; main_bit_1 = 8'(v); v += 1;
            end
            if (v == 20) in_end = 1;
            cycle();
        end
        drain(1);
        check_value("t4_len", out_log.size(), 20);
        if (out_log.size() == 20)
            for (int i = 0; i < 20; i++) check_value("t4_order", out_log[i], 8'(i));

        // Reset in the middle of FLUSH with five bytes queued.
        start_frame();
        out_ready = 0;
        main_flag = 2'b11; main_bit_1 = 8'h01; main_bit_2 = 8'h02;
        cycle();
        main_flag = 2'b11; main_bit_1 = 8'h03; main_bit_2 = 8'h04;
        cycle();
        main_flag = 2'b01; main_bit_1 = 8'h05; in_end = 1;
        cycle();
        clear_inputs();
        cycle();
        check_value("t6_flush_busy", busy, 1);
        apply_reset();
        start_frame();
        out_ready = 1;
        main_flag = 2'b01; main_bit_1 = 8'h77; in_end = 1;
        cycle();
        drain(0);
        check_value("t6_len", out_log.size(), 1);
        if (out_log.size() == 1) check_value("t6_byte", out_log[0], 8'h77);

        // Randomized frames with all flag codes and stray control pulses.
        for (int f = 0; f < 8; f++) begin
            int len, rdy_pct;
            start_frame();
            len = $urandom_range(5, 40);
            rdy_pct = (f % 3 == 0) ? 20 : 75;
            for (int c = 0; c < len; c++) begin
                main_flag  = 2'($urandom);
                aux_flag   = 3'($urandom);
                sel_aux    = 1'($urandom);
                main_bit_1 = 8'($urandom); main_bit_2 = 8'($urandom);
                aux_bit_1  = 8'($urandom); aux_bit_2  = 8'($urandom); aux_bit_3 = 8'($urandom);
                in_start   = ($urandom % 8) == 0;
                out_ready  = ($urandom_range(0, 99) < rdy_pct);
                in_end     = (c == len - 1);
                cycle();
            end
            drain(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
